// File: rtl/muldiv_sequencer_if.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer_if
// Handshake and operand/result bundle between the EX stage and the RV32M
// multiply/divide sequencer.
//   start  : EX stage presents a valid M-extension op
//   f3     : funct3 selecting MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   a, b   : rs1 / rs2 operands after forwarding
//   flush  : branch/jump flush, aborts an op in flight
//   stall  : freeze IF/ID/EX and bubble MEM
//   busy   : op in progress
//   done   : one-cycle pulse, result valid
//   result : final value, held until the next done
// master = pipeline side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      f3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, f3, a, b, flush,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, f3, a, b, flush,
        output stall, busy, done, result
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
// Multi-cycle RV32M unit sitting beside the ALU in EX. Multiplies by
// shift-add over a 2*XLEN product register and divides by restoring
// shift-subtract, both on operand magnitudes; the sign is reapplied in FIX.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : muldiv_sequencer_if slave (start/f3/a/b/flush in,
//          stall/busy/done/result out)
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    muldiv_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    localparam int              CW      = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] neg_word(input logic [XLEN-1:0] v);
        return ~v + 1'b1;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_dword(input logic [2*XLEN-1:0] v);
        return ~v + 1'b1;
    endfunction

    state_t            state, state_next;
    logic [2:0]        op;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mcand;
    logic [XLEN-1:0]   divisor;
    logic [XLEN-1:0]   rem_r;
    logic [XLEN-1:0]   quo_r;
    logic              q_neg;   // sign of product or quotient
    logic              r_neg;   // sign of remainder
    logic [XLEN-1:0]   result;

    // Decode of the op being offered this cycle
    logic signed [XLEN-1:0] a_s, b_s;
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            is_div, b_zero, div_ovf, special, accept;

    assign a_s      = bus.a;
    assign b_s      = bus.b;
    assign a_signed = (bus.f3 == 3'b001) || (bus.f3 == 3'b010) ||
                      (bus.f3 == 3'b100) || (bus.f3 == 3'b110);
    assign b_signed = (bus.f3 == 3'b001) || (bus.f3 == 3'b100) ||
                      (bus.f3 == 3'b110);
    assign a_neg    = a_signed && (a_s < 0);
    assign b_neg    = b_signed && (b_s < 0);
    assign mag_a    = a_neg ? neg_word(bus.a) : bus.a;
    assign mag_b    = b_neg ? neg_word(bus.b) : bus.b;
    assign is_div   = bus.f3[2];
    assign b_zero   = (bus.b == '0);
    // Signed overflow: most-negative / -1
    assign div_ovf  = is_div && !bus.f3[0] && (bus.a == MIN_NEG) && (bus.b == '1);
    assign special  = is_div && (b_zero || div_ovf);
    assign accept   = (state == IDLE) && bus.start && !bus.flush;

    // One iteration step
    logic [XLEN:0] psum, shifted, diff;

    assign psum    = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
    assign shifted = {rem_r, quo_r[XLEN-1]};
    // diff[XLEN] set means the trial subtract went negative: restore
    assign diff    = shifted - {1'b0, divisor};

    // Sign fix-up and result selection
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

    assign prod_fix = q_neg ? neg_dword(prod) : prod;
    assign quo_fix  = q_neg ? neg_word(quo_r) : quo_r;
    assign rem_fix  = r_neg ? neg_word(rem_r) : rem_r;
    assign fix_val  = op[2] ? (op[1] ? rem_fix : quo_fix)
                            : ((op == 3'b000) ? prod_fix[XLEN-1:0]
                                              : prod_fix[2*XLEN-1:XLEN]);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    logic stall, busy, done;

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall      = 1'b1;
                    state_next = special ? FIX : ITER;
                end
            end
            ITER: begin
                stall = 1'b1;
                busy  = 1'b1;
                if (bus.flush)          state_next = IDLE;
                else if (count == LAST) state_next = FIX;
            end
            FIX: begin
                stall      = 1'b1;
                busy       = 1'b1;
                state_next = bus.flush ? IDLE : DONE;
            end
            DONE: begin
                // start still shows the finished instruction; not re-accepted
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op      <= '0;
            count   <= '0;
            prod    <= '0;
            mcand   <= '0;
            divisor <= '0;
            rem_r   <= '0;
            quo_r   <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op      <= bus.f3;
                        count   <= '0;
                        prod    <= {{XLEN{1'b0}}, mag_a};
                        mcand   <= mag_b;
                        divisor <= mag_b;
                        quo_r   <= mag_a;
                        rem_r   <= '0;
                        q_neg   <= is_div ? ((a_neg ^ b_neg) && !b_zero) : (a_neg ^ b_neg);
                        r_neg   <= a_neg;
                        // Special divides load final values directly
                        if (is_div && b_zero) begin
                            quo_r <= '1;
                            rem_r <= bus.a;
                            q_neg <= 1'b0;
                            r_neg <= 1'b0;
                        end else if (div_ovf) begin
                            quo_r <= MIN_NEG;
                            rem_r <= '0;
                            q_neg <= 1'b0;
                            r_neg <= 1'b0;
                        end
                    end
                end
                ITER: begin
                    if (!bus.flush) begin
                        count <= count + CW'(1);
                        if (op[2]) begin
                            if (!diff[XLEN]) begin
                                rem_r <= diff[XLEN-1:0];
                                quo_r <= {quo_r[XLEN-2:0], 1'b1};
                            end else begin
                                rem_r <= shifted[XLEN-1:0];
                                quo_r <= {quo_r[XLEN-2:0], 1'b0};
                            end
                        end else begin
                            prod <= {psum, prod[XLEN-1:1]};
                        end
                    end
                end
                FIX: begin
                    if (!bus.flush) result <= fix_val;
                end
                default: ;
            endcase
        end
    end

    assign bus.stall  = stall;
    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
// Directed bench for the RV32M sequencer: reset state, each op class with
// hand-computed results and latencies, divide special cases, flush abort,
// mid-op reset and start held through DONE.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    muldiv_sequencer_if bus_if ();

    muldiv_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current cycle, scramble operands while busy,
    // and check latency, result and stall behaviour.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int lat);
        int n;
        bit seen;
        bit stall_bad;
        bus_if.f3    = f;
        bus_if.a     = x;
        bus_if.b     = y;
        bus_if.flush = 1'b0;
        bus_if.start = 1'b1;
        #1;
        chk({tag, " stall_issue"}, 64'(bus_if.stall), 64'd1);
        n = 0;
        seen = 1'b0;
        stall_bad = 1'b0;
        while (!seen && n < 60) begin
            tick();
            n++;
            bus_if.a  = $urandom;
            bus_if.b  = $urandom;
            bus_if.f3 = 3'($urandom);
            #1;
            if (bus_if.done) seen = 1'b1;
            else if (!bus_if.stall) stall_bad = 1'b1;
        end
        chk({tag, " latency"}, seen ? 64'(n) : 64'd999, 64'(lat));
        chk({tag, " result"}, 64'(bus_if.result), 64'(exp));
        chk({tag, " stall_at_done"}, 64'(bus_if.stall), 64'd0);
        chk({tag, " stall_gap"}, 64'(stall_bad), 64'd0);
        tick();
        bus_if.start = 1'b0;
        #1;
        chk({tag, " no_retrigger"}, 64'({bus_if.busy, bus_if.done}), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        rst          = 1'b1;
        bus_if.start = 1'b0;
        bus_if.flush = 1'b0;
        bus_if.f3    = 3'd0;
        bus_if.a     = '0;
        bus_if.b     = '0;
        tick();
        tick();
        chk("reset stall",  64'(bus_if.stall),  64'd0);
        chk("reset busy",   64'(bus_if.busy),   64'd0);
        chk("reset done",   64'(bus_if.done),   64'd0);
        chk("reset result", 64'(bus_if.result), 64'd0);
        rst = 1'b0;
        tick();

        run_op("MUL",         3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        run_op("MULH",        3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
        run_op("MULHU",       3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 34);
        run_op("MULHSU",      3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34);
        run_op("MULH_m1m1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34);
        run_op("DIV",         3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
        run_op("REM",         3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
        run_op("DIVU",        3'b101, 32'd100,      32'd7,        32'd14,       34);
        run_op("REMU",        3'b111, 32'd100,      32'd7,        32'd2,        34);
        run_op("DIVU_by0",    3'b101, 32'h1234,     32'd0,        32'hFFFFFFFF, 2);
        run_op("REMU_by0",    3'b111, 32'h1234,     32'd0,        32'h1234,     2);
        run_op("DIV_by0",     3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 2);
        run_op("REM_by0",     3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 2);
        run_op("DIV_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
        run_op("REM_ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2);

        // Flush in the 10th ITER cycle of a divide
        bus_if.f3    = 3'b101;
        bus_if.a     = 32'd100;
        bus_if.b     = 32'd7;
        bus_if.start = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        bus_if.flush = 1'b1;
        bus_if.start = 1'b0;
        tick();
        bus_if.flush = 1'b0;
        #1;
        chk("flush stall",  64'(bus_if.stall),  64'd0);
        chk("flush busy",   64'(bus_if.busy),   64'd0);
        chk("flush done",   64'(bus_if.done),   64'd0);
        chk("flush result", 64'(bus_if.result), 64'd0);
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus_if.done) dc++;
        end
        chk("flush no_done", 64'(dc), 64'd0);

        // Flush together with start in IDLE is not accepted
        bus_if.f3    = 3'b000;
        bus_if.a     = 32'd3;
        bus_if.b     = 32'd5;
        bus_if.start = 1'b1;
        bus_if.flush = 1'b1;
        #1;
        chk("idle_flush stall", 64'(bus_if.stall), 64'd0);
        tick();
        bus_if.start = 1'b0;
        bus_if.flush = 1'b0;
        #1;
        chk("idle_flush busy", 64'(bus_if.busy), 64'd0);

        run_op("MUL_3x5", 3'b000, 32'd3, 32'd5, 32'd15, 34);

        // Reset in the middle of ITER
        bus_if.f3    = 3'b000;
        bus_if.a     = 32'd9;
        bus_if.b     = 32'd9;
        bus_if.start = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("pre_rst busy", 64'(bus_if.busy), 64'd1);
        rst          = 1'b1;
        bus_if.start = 1'b0;
        tick();
        chk("midrst stall",  64'(bus_if.stall),  64'd0);
        chk("midrst busy",   64'(bus_if.busy),   64'd0);
        chk("midrst done",   64'(bus_if.done),   64'd0);
        chk("midrst result", 64'(bus_if.result), 64'd0);
        rst = 1'b0;
        tick();

        run_op("MULHU_max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller and datapath for the RV32M instructions, attached beside the ALU in the EX stage.
- Accepts one multiply/divide op, iterates it with shift-add (multiply) or restoring shift-subtract (divide), then returns a 32-bit result.
- Holds the pipeline through `stall` while busy. `stall` is ORed into the hazard-detection write-enable / empty-control path.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  EX stage holds a valid M-extension op (op=0110011, f7=0000001).
- f3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  XLEN  rs1 operand, after forwarding.
- b  input  XLEN  rs2 operand, after forwarding.
- flush  input  1  branch/jump flush from jump control; aborts the op.
- stall  output  1  freeze IF/ID/EX, insert bubble into MEM.
- busy  output  1  op in progress (state ITER or FIX).
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  final value; held until the next done.

Behaviour:
- Reset (rst=1 at a clock edge) forces: state IDLE, count 0, result 0, done 0, busy 0, internal registers 0. Reset wins over every other input, in any state.
- States: IDLE, ITER, FIX, DONE.
- IDLE, start=1, flush=0 (call this cycle C):
  - Latch f3 and operand magnitudes.
  - Signed operands are DIV/REM both, MULH both, MULHSU rs1 only. Negate an operand if signed and its MSB is 1.
  - Record the result sign:
    - multiply: sign(a) XOR sign(b);
    - quotient: the same, forced positive when b=0;
    - remainder: sign(a).
  - count := 0. Next state is ITER, or FIX for the special cases below.
- Divide special cases skip ITER and go straight to FIX:
  - b=0: quotient 0xFFFFFFFF, remainder = a.
  - Signed DIV/REM with a=0x80000000 and b=0xFFFFFFFF: quotient 0x80000000, remainder 0.
  - done at cycle C+2.
- ITER: one multiply or divide step per cycle, count increments. After the step with count=XLEN-1, go to FIX.
  - Multiply keeps a 2*XLEN product register.
  - Divide keeps XLEN-bit remainder and quotient registers; the remainder subtract is XLEN+1 bits wide.
- FIX (one cycle):
  - Apply two's-complement negation if the recorded sign is negative.
  - Select the result: MUL → low word, MULH* → high word, DIV* → quotient, REM* → remainder.
  - Write `result`, then go to DONE.
- DONE (one cycle): done=1, stall=0 so the pipeline advances. start is ignored in this cycle (the same instruction is still presented). Next state is IDLE.
- Normal latency: done is asserted in cycle C+XLEN+2, i.e. C+34 for XLEN=32.
- stall = (state==IDLE && start && !flush) || state==ITER || state==FIX. It is combinational from start, so the issuing cycle is already stalled.
- busy = (state==ITER || state==FIX).
- flush=1 in any non-IDLE state returns to IDLE at the next edge:
  - done is not asserted and result is unchanged;
  - flush in IDLE with start=1 is not accepted.
- A back-to-back op is accepted in the IDLE cycle directly after DONE. Minimum issue interval is XLEN+3 cycles.
- Operand inputs are sampled only at acceptance. Changes on a/b/f3 while busy have no effect.

Test Plan:
- MUL a=7, b=0xFFFFFFFD, start at cycle 0 → stall high cycles 0–33; done=1 and result=0xFFFFFFEB in cycle 34; stall=0 in cycle 34.
- MULH a=b=0x80000000 → result 0x40000000. MULHU same operands → 0x40000000. MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD (−3). REM same operands → 0xFFFFFFFF (−1). DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU a=0x1234, b=0 → 0xFFFFFFFF at cycle 2. REMU same → 0x1234. DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000, REM → 0, both with done at cycle 2.
- Start DIV, assert flush in the 10th ITER cycle → state IDLE next cycle; stall and busy 0; no done pulse; result keeps its previous value. A new MUL 3×5 then returns 15.
- rst=1 mid-ITER → next cycle all outputs 0; a start after reset deasserts completes normally. Also: start held high through DONE must not retrigger.
